// File: rtl/date_pkg.sv
// Shared calendar types, month constants and leap-year rule for the date counter.
// Leap rule only needs to hold for years 2000-2099, where every fourth year is leap.
package date_pkg;

  typedef logic [4:0] day_t;
  typedef logic [3:0] month_t;

  localparam month_t MONTH_JAN = 4'd1;
  localparam month_t MONTH_FEB = 4'd2;
  localparam month_t MONTH_MAR = 4'd3;
  localparam month_t MONTH_APR = 4'd4;
  localparam month_t MONTH_MAY = 4'd5;
  localparam month_t MONTH_JUN = 4'd6;
  localparam month_t MONTH_JUL = 4'd7;
  localparam month_t MONTH_AUG = 4'd8;
  localparam month_t MONTH_SEP = 4'd9;
  localparam month_t MONTH_OCT = 4'd10;
  localparam month_t MONTH_NOV = 4'd11;
  localparam month_t MONTH_DEC = 4'd12;

  localparam day_t       DAY_MIN    = 5'd1;
  localparam logic [2:0] RESET_WDAY = 3'd6;

  // 2100 is outside the counted range, so the century exception never applies.
  function automatic logic is_leap(input logic [6:0] year);
    return (year % 7'd4) == 7'd0;
  endfunction

endpackage

// File: rtl/date_counter_month_len.sv
// Combinational month length lookup: (month, year offset) -> number of days.
// Out-of-range month codes report 31 so a corrupted state still rolls over.
module month_len
  import date_pkg::*;
(
  input  month_t     month,
  input  logic [6:0] year,
  output day_t       len
);

  always_comb begin
    len = 5'd31;
    case (month)
      MONTH_FEB: len = is_leap(year) ? 5'd29 : 5'd28;
      MONTH_APR,
      MONTH_JUN,
      MONTH_SEP,
      MONTH_NOV: len = 5'd30;
      default:   len = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// Day/month/year calendar advanced by the hour counter's wrap pulse; 1-cycle update, load beats tick.
// Optional weekday tracking is built when DATE_COUNTER_WEEKDAY_EN is defined.
module date_counter
  import date_pkg::*;
#(
  parameter int YEAR_BITS = 7,
  parameter int YEAR_MAX  = 99
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 day_tick,
  input  logic                 load,
  input  logic [15:0]          data,
  input  logic                 enable,
`ifdef DATE_COUNTER_WEEKDAY_EN
  input  logic [2:0]           wday_data,
  output logic [2:0]           weekday,
`endif
  output day_t                 day,
  output month_t               month,
  output logic [YEAR_BITS-1:0] year,
  output logic                 year_wrap,
  output logic [15:0]          databus
);

  day_t                 day_q, day_d;
  month_t               month_q, month_d;
  logic [YEAR_BITS-1:0] year_q, year_d;
  logic                 year_wrap_q, year_wrap_d;

  logic [6:0] ld_year_raw;
  month_t     ld_month_raw;
  day_t       ld_day_raw;
  logic [6:0] ld_year;
  month_t     ld_month;
  day_t       ld_day;
  day_t       ld_len;
  day_t       cur_len;

  assign ld_year_raw  = data[15:9];
  assign ld_month_raw = data[8:5];
  assign ld_day_raw   = data[4:0];

  // Preset fields are clamped before the day is checked against its month.
  assign ld_month = (ld_month_raw == 4'd0 || ld_month_raw > MONTH_DEC) ? MONTH_JAN : ld_month_raw;
  assign ld_year  = (int'(ld_year_raw) > YEAR_MAX) ? 7'(YEAR_MAX) : ld_year_raw;
  assign ld_day   = (ld_day_raw == 5'd0)   ? DAY_MIN :
                    (ld_day_raw > ld_len)  ? ld_len  : ld_day_raw;

  month_len u_len_load (
    .month (ld_month),
    .year  (ld_year),
    .len   (ld_len)
  );

  month_len u_len_cur (
    .month (month_q),
    .year  (7'(year_q)),
    .len   (cur_len)
  );

  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    year_wrap_d = 1'b0;
    if (load) begin
      day_d   = ld_day;
      month_d = ld_month;
      year_d  = YEAR_BITS'(ld_year);
    end else if (day_tick) begin
      // ">=" lets an out-of-range day roll over instead of counting up to 31.
      if (day_q < cur_len) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d = DAY_MIN;
        if (month_q < MONTH_DEC) begin
          month_d = month_q + 4'd1;
        end else begin
          month_d = MONTH_JAN;
          if (int'(year_q) >= YEAR_MAX) begin
            year_d      = '0;
            year_wrap_d = 1'b1;
          end else begin
            year_d = year_q + YEAR_BITS'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      day_q       <= DAY_MIN;
      month_q     <= MONTH_JAN;
      year_q      <= '0;
      year_wrap_q <= 1'b0;
    end else begin
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      year_wrap_q <= year_wrap_d;
    end
  end

`ifdef DATE_COUNTER_WEEKDAY_EN
  logic [2:0] wday_q, wday_d;

  always_comb begin
    wday_d = wday_q;
    if (load) begin
      wday_d = (wday_data == 3'd7) ? 3'd0 : wday_data;
    end else if (day_tick) begin
      wday_d = (wday_q >= 3'd6) ? 3'd0 : wday_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wday_q <= RESET_WDAY;
    end else begin
      wday_q <= wday_d;
    end
  end

  assign weekday = wday_q;
`endif

  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign year_wrap = year_wrap_q;
  assign databus   = enable ? {7'(year_q), month_q, day_q} : 16'h0000;

endmodule
